// File: rtl/lsu_pkg.sv
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared size encodings, FSM state enumeration and byte-lane
//                constants for the load/store unit.
//                Optional feature macro: LSU_MISALIGN_TRAP_EN (adds ST_ERR).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  // Access size encodings (2'b11 behaves as a word access)
  localparam logic [1:0] c_sz_byte = 2'b00;
  localparam logic [1:0] c_sz_half = 2'b01;
  localparam logic [1:0] c_sz_word = 2'b10;

  // Byte-lane geometry of a 32-bit little-endian word
  localparam int c_lane_w     = 8;
  localparam int c_num_lanes  = 4;
  localparam int c_lane_idx_w = $clog2(c_num_lanes);

  // Controller states, explicitly encoded
`ifdef LSU_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } lsu_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_DONE = 3'd3
  } lsu_state_t;
`endif

  // Full-word access (the spare encoding is folded into word)
  function automatic logic is_word(input logic [1:0] size);
    return (size == c_sz_word) || (size == 2'b11);
  endfunction

  // Address not naturally aligned for the requested size
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [c_lane_idx_w-1:0] lo);
    logic v;
    v = 1'b0;
    if (is_word(size))
      v = (lo != '0);
    else if (size == c_sz_half)
      v = lo[0];
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane.sv
// ============================================================================
//  Module      : lsu_lane
//  Description : Combinational byte-lane logic. Extracts and sign/zero-extends
//                the addressed lane of a memory word for loads, and merges
//                store data into the addressed lane(s) of an old word.
//                Half ignores addr[0]; word ignores addr[1:0].
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_lane
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]              size,
  input  logic                    ld_unsigned,
  input  logic [c_lane_idx_w-1:0] addr_lo,
  input  logic [DATA_WIDTH-1:0]   rd_word,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   ld_data,
  output logic [DATA_WIDTH-1:0]   st_word
);

  logic [4:0]            w_byte_sh;
  logic [4:0]            w_half_sh;
  logic [c_lane_w-1:0]   w_byte;
  logic [2*c_lane_w-1:0] w_half;

  // Bit offsets of the addressed byte and (force-aligned) halfword
  assign w_byte_sh = {addr_lo, 3'b000};
  assign w_half_sh = {addr_lo[1], 4'b0000};

  // Load path: pick the lane and extend it to a full word
  always_comb begin
    w_byte  = rd_word[w_byte_sh +: c_lane_w];
    w_half  = rd_word[w_half_sh +: 2*c_lane_w];
    ld_data = rd_word;
    case (size)
      c_sz_byte: ld_data = {{(DATA_WIDTH-c_lane_w){~ld_unsigned & w_byte[c_lane_w-1]}}, w_byte};
      c_sz_half: ld_data = {{(DATA_WIDTH-2*c_lane_w){~ld_unsigned & w_half[2*c_lane_w-1]}}, w_half};
      default:   ld_data = rd_word;
    endcase
  end

  // Store path: overlay right-justified store data onto the old word
  always_comb begin
    st_word = rd_word;
    case (size)
      c_sz_byte: st_word[w_byte_sh +: c_lane_w]   = wdata[c_lane_w-1:0];
      c_sz_half: st_word[w_half_sh +: 2*c_lane_w] = wdata[2*c_lane_w-1:0];
      default:   st_word = wdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// ============================================================================
//  Module      : lsu_ctrl
//  Description : Load/store unit controller for a word-indexed data memory
//                (combinational read, synchronous write). Loads take
//                IDLE->RD->DONE, word stores IDLE->WR->DONE, byte/half stores
//                do a read-modify-write IDLE->RD->WR->DONE.
//                Optional feature macro: LSU_MISALIGN_TRAP_EN - misaligned
//                half/word requests trap through ST_ERR instead of being
//                force-aligned.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  st,
  input  logic [1:0]            size,
  input  logic                  ld_unsigned,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ack,
  output logic                  busy,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  lsu_state_t            r_state;
  lsu_state_t            w_next;

  logic                  r_st;
  logic [1:0]            r_size;
  logic                  r_uns;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_merge;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic [DATA_WIDTH-1:0] w_ld_data;
  logic [DATA_WIDTH-1:0] w_st_word;
  logic                  w_accept;

  assign w_accept = (r_state == ST_IDLE) && req;

  // Word index is derived from the captured address, so it stays put RD..WR
  assign mem_addr = {2'b00, r_addr[ADDR_WIDTH-1:2]};
  assign rdata    = r_rdata;

  lsu_lane #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane (
    .size        (r_size),
    .ld_unsigned (r_uns),
    .addr_lo     (r_addr[c_lane_idx_w-1:0]),
    .rd_word     (mem_rd),
    .wdata       (r_wdata),
    .ld_data     (w_ld_data),
    .st_word     (w_st_word)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Request capture; only an idle controller latches a new access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_st    <= st;
      r_size  <= size;
      r_uns   <= ld_unsigned;
      r_addr  <= addr;
      r_wdata <= wdata;
    end
  end

  // RD-cycle data capture: merged word for RMW stores, extended lane for loads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_merge <= '0;
      r_rdata <= '0;
    end else if (r_state == ST_RD) begin
      if (r_st) r_merge <= w_st_word;
      else      r_rdata <= w_ld_data;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
`ifdef LSU_MISALIGN_TRAP_EN
          if (is_misaligned(size, addr[c_lane_idx_w-1:0]))
            w_next = ST_ERR;
          else
`endif
          if (st && is_word(size))
            w_next = ST_WR;
          else
            w_next = ST_RD;
        end
      end
      ST_RD:   w_next = r_st ? ST_WR : ST_DONE;
      ST_WR:   w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
      ST_ERR:  w_next = ST_IDLE;
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    busy   = (r_state != ST_IDLE);
    ack    = 1'b0;
    err    = 1'b0;
    mem_re = 1'b0;
    mem_we = 1'b0;
    mem_wd = is_word(r_size) ? r_wdata : r_merge;
    case (r_state)
      ST_RD:   mem_re = 1'b1;
      ST_WR:   mem_we = 1'b1;
      ST_DONE: ack    = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
      ST_ERR: begin
        ack = 1'b1;
        err = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// ============================================================================
//  Module      : tb_lsu_ctrl
//  Description : Self-checking bench for lsu_ctrl with a word-indexed memory
//                and a byte-arithmetic reference model.
//                Honours LSU_MISALIGN_TRAP_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        st;
  logic [1:0]  size;
  logic        ld_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        busy;
  logic        err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rd;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  logic        pl_we;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;
  logic [31:0] ref_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .st          (st),
    .size        (size),
    .ld_unsigned (ld_unsigned),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .ack         (ack),
    .busy        (busy),
    .err         (err),
    .mem_addr    (mem_addr),
    .mem_wd      (mem_wd),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .mem_rd      (mem_rd)
  );

  // Data memory: combinational read, synchronous write, plus a preload port
  assign mem_rd = mem[mem_addr[5:0]];
  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr[5:0]] <= mem_wd;
    else if (pl_we) mem[pl_idx]        <= pl_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference load: shift the addressed lane down, mask, then extend
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic uns, input logic [7:0] a);
    int          ai;
    int          sh;
    logic [31:0] v;
    ai = int'(a);
    if (sz == 2'd0) begin
      sh = (ai % 4) * 8;
      v  = (w >> sh) & 32'h0000_00FF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      sh = ((ai / 2) % 2) * 16;
      v  = (w >> sh) & 32'h0000_FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // Reference store: masked overlay of shifted store data
  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [1:0] sz,
                                            input logic [7:0] a, input logic [31:0] wd);
    int          ai;
    int          sh;
    logic [31:0] m;
    ai = int'(a);
    if (sz == 2'd0) begin
      sh = (ai % 4) * 8;
      m  = 32'h0000_00FF << sh;
    end else if (sz == 2'd1) begin
      sh = ((ai / 2) % 2) * 16;
      m  = 32'h0000_FFFF << sh;
    end else begin
      sh = 0;
      m  = 32'hFFFF_FFFF;
    end
    return (old & ~m) | ((wd << sh) & m);
  endfunction

  function automatic bit ref_trap(input logic [1:0] sz, input logic [7:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    int ai;
    ai = int'(a);
    return (sz >= 2'd2 && (ai % 4) != 0) || (sz == 2'd1 && (ai % 2) != 0);
`else
    return (sz == 2'd3) && (a == 8'hFF) && 1'b0;
`endif
  endfunction

  // One complete access with cycle-by-cycle observation
  task automatic do_access(input logic s, input logic [1:0] sz, input logic u,
                           input logic [7:0] a, input logic [31:0] wd, input string tag);
    bit          trap;
    int          exp_ack_k, exp_re, exp_we;
    int          ack_k, re_n, we_n;
    logic        err_seen;
    logic [31:0] exp_idx;
    trap     = ref_trap(sz, a);
    exp_idx  = {24'b0, a} >> 2;
    ack_k    = 0;
    re_n     = 0;
    we_n     = 0;
    err_seen = 1'b0;
    if (trap) begin
      exp_ack_k = 1; exp_re = 0; exp_we = 0;
    end else if (!s) begin
      exp_ack_k = 2; exp_re = 1; exp_we = 0;
      ref_rdata = ref_load(ref_mem[a[7:2]], sz, u, a);
    end else if (sz >= 2'd2) begin
      exp_ack_k = 2; exp_re = 0; exp_we = 1;
      ref_mem[a[7:2]] = wd;
    end else begin
      exp_ack_k = 3; exp_re = 1; exp_we = 1;
      ref_mem[a[7:2]] = ref_store(ref_mem[a[7:2]], sz, a, wd);
    end

    @(negedge clk);
    req = 1'b1; st = s; size = sz; ld_unsigned = u; addr = {24'b0, a}; wdata = wd;
    for (int k = 1; k <= 6 && ack_k == 0; k++) begin
      @(negedge clk);
      if (mem_re) begin re_n++; check({tag, ".re_addr"}, mem_addr, exp_idx); end
      if (mem_we) begin we_n++; check({tag, ".we_addr"}, mem_addr, exp_idx); end
      if (ack) begin
        ack_k    = k;
        err_seen = err;
        check({tag, ".busy_at_ack"}, 32'(busy), 32'd1);
        req = 1'b0;
      end else begin
        // Scramble the request inputs while busy; they must be ignored
        req         = 1'($urandom_range(0, 1));
        st          = 1'($urandom_range(0, 1));
        size        = 2'($urandom_range(0, 3));
        ld_unsigned = 1'($urandom_range(0, 1));
        addr        = $urandom;
        wdata       = $urandom;
      end
    end
    req = 1'b0;
    check({tag, ".ack_cycle"}, 32'(ack_k), 32'(exp_ack_k));
    check({tag, ".re_count"},  32'(re_n),  32'(exp_re));
    check({tag, ".we_count"},  32'(we_n),  32'(exp_we));
    check({tag, ".err"},       32'(err_seen), 32'(trap));
    check({tag, ".rdata"},     rdata, ref_rdata);
    @(negedge clk);
    check({tag, ".busy_after"}, 32'(busy), 32'd0);
    check({tag, ".ack_after"},  32'(ack),  32'd0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; st = 1'b0; size = 2'b00; ld_unsigned = 1'b0;
    addr = '0; wdata = '0; pl_we = 1'b0; pl_idx = '0; pl_data = '0;
    ref_rdata = '0;

    // Preload memory while held in reset
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      pl_we   = 1'b1;
      pl_idx  = 6'(i);
      pl_data = (i == 5) ? 32'h8899_AABB : (i == 3) ? 32'h1122_3344 : $urandom;
      ref_mem[i] = pl_data;
    end
    @(negedge clk);
    pl_we = 1'b0;

    // Reset state
    check("rst.rdata",  rdata,          32'h0);
    check("rst.ack",    32'(ack),       32'd0);
    check("rst.busy",   32'(busy),      32'd0);
    check("rst.err",    32'(err),       32'd0);
    check("rst.mem_we", 32'(mem_we),    32'd0);
    check("rst.mem_re", 32'(mem_re),    32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    do_access(1'b0, 2'd0, 1'b0, 8'h15, 32'h0, "ld_b_s");
    check("ld_b_s.const", rdata, 32'hFFFF_FFAA);
    do_access(1'b0, 2'd1, 1'b1, 8'h16, 32'h0, "ld_h_u");
    check("ld_h_u.const", rdata, 32'h0000_8899);
    do_access(1'b1, 2'd0, 1'b0, 8'h0D, 32'h0000_00EE, "st_b");
    check("st_b.mem3", mem[3], 32'h1122_EE44);
    check("st_b.rdata_kept", rdata, 32'h0000_8899);
    do_access(1'b1, 2'd2, 1'b0, 8'h20, 32'hDEAD_BEEF, "st_w");
    check("st_w.mem8", mem[8], 32'hDEAD_BEEF);
    do_access(1'b0, 2'd2, 1'b0, 8'h22, 32'h0, "ld_w_mis");
`ifdef LSU_MISALIGN_TRAP_EN
    check("ld_w_mis.const", rdata, 32'h0000_8899);
`else
    check("ld_w_mis.const", rdata, 32'hDEAD_BEEF);
`endif

    // Reset during RD of a byte store aborts without writing
    @(negedge clk);
    req = 1'b1; st = 1'b1; size = 2'd0; ld_unsigned = 1'b0; addr = 32'h31; wdata = 32'h55;
    @(negedge clk);
    req = 1'b0;
    check("abort.in_rd", 32'(mem_re), 32'd1);
    rst = 1'b1;
    #1;
    check("abort.busy",   32'(busy),   32'd0);
    check("abort.mem_re", 32'(mem_re), 32'd0);
    check("abort.ack",    32'(ack),    32'd0);
    check("abort.rdata",  rdata,       32'h0);
    ref_rdata = '0;
    @(negedge clk);
    check("abort.mem_we", 32'(mem_we), 32'd0);
    check("abort.ack2",   32'(ack),    32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort.mem12", mem[12], ref_mem[12]);
    do_access(1'b0, 2'd0, 1'b1, 8'h15, 32'h0, "post_abort");

    // Randomized accesses
    for (int i = 0; i < 80; i++) begin
      do_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                $urandom, "rnd");
    end

    // Whole-memory comparison against the reference model
    for (int i = 0; i < 64; i++) check("final.mem", mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
